// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit. Rotate support is compiled in
// only when SEQ_SHIFT_ROTATE_EN is defined.
package shift_pkg;

   typedef enum logic [1:0] {
      SHIFT_LOGICAL = 2'b00,
      SHIFT_ARITH   = 2'b01,
      SHIFT_ROTATE  = 2'b10,
      SHIFT_RSVD    = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   // Reserved and (when not built) rotate encodings collapse to logical.
   function automatic mode_e decode_mode(input logic [1:0] m);
      mode_e r;
      case (m)
         2'b01:   r = SHIFT_ARITH;
`ifdef SEQ_SHIFT_ROTATE_EN
         2'b10:   r = SHIFT_ROTATE;
`endif
         default: r = SHIFT_LOGICAL;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational partial shift: moves data by k (1..STEP) bits in one clock.
// Rotate fill is only built when SEQ_SHIFT_ROTATE_EN is defined.
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned STEP  = 1,
   parameter int unsigned K_W   = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [K_W-1:0]   k_i,
   input  mode_e            mode_i,
   input  dir_e             dir_i,
   output logic [WIDTH-1:0] data_o,
   output logic             carry_o
);

   logic [WIDTH-1:0] acc;
   logic             cy;
   logic             fill;

   // Chain of single-bit stages; stage i is active only when i < k.
   always_comb begin
      acc  = data_i;
      cy   = 1'b0;
      fill = 1'b0;
      for (int unsigned i = 0; i < STEP; i++) begin
         if (i < 32'(k_i)) begin
            if (dir_i == DIR_LEFT) begin
               fill = 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
               if (mode_i == SHIFT_ROTATE) fill = acc[WIDTH-1];
`endif
               cy  = acc[WIDTH-1];
               acc = {acc[WIDTH-2:0], fill};
            end else begin
               fill = (mode_i == SHIFT_ARITH) ? acc[WIDTH-1] : 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
               if (mode_i == SHIFT_ROTATE) fill = acc[0];
`endif
               cy  = acc[0];
               acc = {fill, acc[WIDTH-1:1]};
            end
         end
      end
      data_o  = acc;
      carry_o = cy;
   end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter with valid/ready on both sides, STEP bits per clock.
// Define SEQ_SHIFT_ROTATE_EN to build rotate support for mode 2'b10.
module seq_shift_unit
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned STEP  = 1,
   parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             shift_dir,
   input  logic [1:0]       mode,
   input  logic [AMT_W-1:0] shift_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   dir_e             dir_q, dir_d;
   mode_e            mode_q, mode_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;

   mode_e            req_mode;
   logic [AMT_W-1:0] n_eff;
   logic [AMT_W-1:0] step_k;
   logic [WIDTH-1:0] step_data;
   logic             step_carry;

   always_comb begin
      req_mode = decode_mode(mode);
      n_eff    = (shift_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : shift_amt;
`ifdef SEQ_SHIFT_ROTATE_EN
      if (req_mode == SHIFT_ROTATE) n_eff = AMT_W'(shift_amt % AMT_W'(WIDTH));
`endif
   end

   assign step_k = (rem_q > AMT_W'(STEP)) ? AMT_W'(STEP) : rem_q;

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .K_W   (AMT_W)
   ) u_step (
      .data_i  (data_q),
      .k_i     (step_k),
      .mode_i  (mode_q),
      .dir_i   (dir_q),
      .data_o  (step_data),
      .carry_o (step_carry)
   );

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      dir_d     = dir_q;
      mode_d    = mode_q;
      rem_d     = rem_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid) begin
               data_d  = in_data;
               dir_d   = dir_e'(shift_dir);
               mode_d  = req_mode;
               rem_d   = n_eff;
               carry_d = 1'b0;
               if (n_eff != '0) begin
                  state_d = SHIFT;
               end else begin
                  state_d = DONE;
                  zero_d  = (in_data == '0);
               end
            end
         end
         SHIFT: begin
            data_d  = step_data;
            carry_d = step_carry;
            rem_d   = rem_q - step_k;
            if (rem_q == step_k) begin
               state_d = DONE;
               zero_d  = (step_data == '0);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         dir_q   <= DIR_LEFT;
         mode_q  <= SHIFT_LOGICAL;
         rem_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign out_data  = data_q;
   assign out_carry = carry_q;
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: one STEP=1 and one STEP=4 instance.
module tb_seq_shift_unit;

   localparam int W  = 8;
   localparam int AW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sel = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          shift_dir = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [AW-1:0] shift_amt = '0;
   logic          out_ready = 1'b0;

   logic          iv [2];
   logic          ir [2];
   logic          ov [2];
   logic [W-1:0]  od [2];
   logic          oc [2];
   logic          oz [2];

   logic          a_ready, a_valid, a_carry, a_zero;
   logic [W-1:0]  a_data;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [W-1:0] d;
      logic         c;
      logic         z;
      int           lat;
   } exp_t;

   exp_t sb [$];

   always #5 clk = ~clk;

   assign iv[0]   = in_valid & ~sel;
   assign iv[1]   = in_valid & sel;
   assign a_ready = sel ? ir[1] : ir[0];
   assign a_valid = sel ? ov[1] : ov[0];
   assign a_data  = sel ? od[1] : od[0];
   assign a_carry = sel ? oc[1] : oc[0];
   assign a_zero  = sel ? oz[1] : oz[0];

   seq_shift_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_data(in_data), .shift_dir(shift_dir), .mode(mode), .shift_amt(shift_amt),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
      .out_carry(oc[0]), .out_zero(oz[0])
   );

   seq_shift_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_data(in_data), .shift_dir(shift_dir), .mode(mode), .shift_amt(shift_amt),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
      .out_carry(oc[1]), .out_zero(oz[1])
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input int step, input logic [W-1:0] d, input logic dir,
                                  input logic [1:0] m, input int amt);
      exp_t e;
      int n;
      logic rot;
      logic [W-1:0] r;
      logic c;
      rot = 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
      rot = (m == 2'b10);
`endif
      if (rot) n = amt % W;
      else     n = (amt > W) ? W : amt;
      r = d;
      c = 1'b0;
      if (n > 0) begin
         if (!dir) begin
            c = d[W-n];
            r = rot ? ((d << n) | (d >> (W - n))) : (d << n);
         end else begin
            c = d[n-1];
            if (rot)             r = (d >> n) | (d << (W - n));
            else if (m == 2'b01) r = $signed(d) >>> n;
            else                 r = d >> n;
         end
      end
      e.d   = r;
      e.c   = c;
      e.z   = (r == '0);
      e.lat = (n + step - 1) / step;
      return e;
   endfunction

   task automatic run_op(input logic s, input logic [W-1:0] d, input logic dir,
                         input logic [1:0] m, input logic [AW-1:0] amt, input int hold);
      int   t;
      exp_t e;
      sel = s;
      t = 0;
      while (!a_ready && t < 50) begin @(negedge clk); t++; end
      chk("accept_ready", a_ready, 1);
      in_valid  = 1'b1;
      in_data   = d;
      shift_dir = dir;
      mode      = m;
      shift_amt = amt;
      sb.push_back(model(s ? 4 : 1, d, dir, m, int'(amt)));
      @(negedge clk);
      in_valid = 1'b0;
      t = 0;
      while (!a_valid && t < 40) begin @(negedge clk); t++; end
      e = sb.pop_front();
      chk("latency", t, e.lat);
      chk("data", a_data, e.d);
      chk("carry", a_carry, e.c);
      chk("zero", a_zero, e.z);
      for (int i = 0; i < hold; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = ~d;
         @(negedge clk);
         chk("bp_valid", a_valid, 1);
         chk("bp_data", a_data, e.d);
         chk("bp_carry", a_carry, e.c);
         chk("bp_zero", a_zero, e.z);
         chk("bp_ready", a_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_valid", a_valid, 0);
      chk("post_ready", a_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      repeat (3) @(negedge clk);
      chk("rst_ready1", ir[0], 0);
      chk("rst_ready4", ir[1], 0);
      chk("rst_valid1", ov[0], 0);
      chk("rst_valid4", ov[1], 0);
      chk("rst_data", od[0], 0);
      chk("rst_carry", oc[0], 0);
      chk("rst_zero", oz[0], 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready1", ir[0], 1);
      chk("idle_ready4", ir[1], 1);

      run_op(1'b0, 8'hB1, 1'b0, 2'b00, 4'd3, 0);
      run_op(1'b0, 8'h90, 1'b1, 2'b01, 4'd2, 0);
      run_op(1'b0, 8'hFF, 1'b1, 2'b00, 4'd15, 0);
      run_op(1'b0, 8'h5A, 1'b0, 2'b10, 4'd0, 0);
      run_op(1'b1, 8'h5A, 1'b1, 2'b01, 4'd0, 0);
      run_op(1'b1, 8'h81, 1'b1, 2'b10, 4'd9, 0);
      run_op(1'b1, 8'h81, 1'b0, 2'b10, 4'd3, 0);
      run_op(1'b1, 8'h01, 1'b0, 2'b00, 4'd8, 0);
      run_op(1'b1, 8'hC5, 1'b1, 2'b11, 4'd6, 0);
      run_op(1'b0, 8'h3C, 1'b0, 2'b00, 4'd2, 5);
      run_op(1'b1, 8'hA7, 1'b1, 2'b01, 4'd7, 5);

      for (int k = 0; k < 40; k++) begin
         run_op(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), $urandom_range(0, 2));
      end

      // Abort a 7-bit STEP=1 shift during its third SHIFT cycle.
      sel = 1'b0;
      chk("abort_ready", a_ready, 1);
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      shift_dir = 1'b0;
      mode      = 2'b00;
      shift_amt = 4'd7;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_rst_ready", a_ready, 0);
      chk("abort_rst_valid", a_valid, 0);
      chk("abort_rst_data", a_data, 0);
      chk("abort_rst_carry", a_carry, 0);
      chk("abort_rst_zero", a_zero, 0);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (a_valid) seen = 1'b1;
      end
      chk("abort_no_result", seen, 0);
      chk("abort_idle_ready", a_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
